ahb_burst_master: RTL and testbench
===================================

AHB_BURST_MASTER -- requirements
Module: ahb_burst_master

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning HWDATA/HRDATA width; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning HADDR width.
REQ-003 HCLK  in  1  single clock; every flop samples on the rising edge.
REQ-004 HRESETn  in  1  reset: asynchronous assert, active-low.
REQ-005 cmd_valid/cmd_ready  in/out  1/1  command handshake; transfer occurs when both are 1 on a rising edge.
REQ-006 cmd_write, cmd_addr, cmd_size, cmd_burst  in  1, ADDR_W, 3, 3  direction, start address, HSIZE and HBURST of the command.
REQ-007 wdata/wvalid/wready  in/in/out  DATA_W/1/1  write-beat stream.
REQ-008 rdata/rvalid/rlast  out  DATA_W/1/1  read-beat stream with no backpressure.
REQ-009 done/err  out  1/1  single-cycle completion pulse; err qualifies done.
REQ-010 HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA  out  ADDR_W, 2, 1, 3, 3, DATA_W  AHB-Lite address and data phase.
REQ-011 HPROT=4'b0011 and HMASTLOCK=0  out  4/1  tied constants.
REQ-012 HRDATA, HREADY, HRESP  in  DATA_W, 1, 1  AHB-Lite slave response.

Function
REQ-013 cmd_ready SHALL be 1 only in IDLE with no data phase outstanding.
REQ-014 Supported bursts SHALL be SINGLE(0), WRAP4(2), INCR4(3), WRAP8(4), INCR8(5), WRAP16(6) and INCR16(7); an INCR(1) command SHALL be executed as SINGLE.
REQ-015 Beat count SHALL be 1, 4, 8 or 16; the address step SHALL be 1<<cmd_size bytes.
REQ-016 For WRAPn bursts, the address SHALL wrap at an n*(1<<size)-byte aligned boundary; upper address bits SHALL be held.
REQ-017 cmd_size > log2(DATA_W/8) or a misaligned cmd_addr SHALL NOT issue any bus transfer; done=1 and err=1 SHALL pulse the cycle after acceptance.
REQ-018 FSM states SHALL be IDLE, NSEQ, SEQ, BUSY, ERR1, ERR2 and DRAIN.
REQ-019 HTRANS SHALL be IDLE=00 in IDLE/ERR2/DRAIN, NONSEQ=10 in NSEQ, SEQ=11 in SEQ, BUSY=01 in BUSY and IDLE=00 in ERR1.
REQ-020 IDLE->NSEQ SHALL occur on acceptance for a read; for a write it SHALL occur on acceptance with wvalid=1, otherwise the FSM SHALL wait in IDLE with cmd_ready=0.
REQ-021 The address phase SHALL advance only on HREADY=1; HADDR/HTRANS/controls SHALL be held stable while HREADY=0.
REQ-022 Next beat after an advance: SEQ if beats remain and (read or wvalid=1); BUSY if beats remain, it is a write and wvalid=0; DRAIN after the last beat.
REQ-023 BUSY SHALL hold the next-beat HADDR and go to SEQ once wvalid=1 and HREADY=1.
REQ-024 wready SHALL pulse for one cycle when a write address phase is accepted (HREADY=1 in NSEQ/SEQ); wdata SHALL be registered then and driven on HWDATA through the following data phase, stable across wait states.
REQ-025 A read data phase completing with HREADY=1, HRESP=0 SHALL produce rvalid=1 with rdata=HRDATA the same cycle; rlast=1 SHALL mark the final beat.
REQ-026 DRAIN SHALL wait for the final data phase HREADY=1, then pulse done=1, err=0 and return to IDLE.
REQ-027 On HRESP=1 with HREADY=0 (first error cycle), the next cycle SHALL enter ERR1 with HTRANS=IDLE, cancelling remaining beats, and no rvalid SHALL be issued for the errored beat.
REQ-028 ERR1 SHALL move to ERR2 on HREADY=1; ERR2 SHALL pulse done=1, err=1 and return to IDLE.
REQ-029 A 4-bit beat counter SHALL count remaining address phases and wrap neither below 0 nor above 15; a 1-bit flag SHALL track an outstanding data phase.
REQ-030 HWDATA SHALL be 0 when no write data phase is outstanding; data_out-style outputs SHALL be combinationally zero outside valid cycles.

Reset
REQ-031 HRESETn=0 SHALL force, asynchronously: FSM to IDLE, HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HWDATA=0, cmd_ready=0, wready=0, rvalid=0, rlast=0, done=0, err=0, and clear the counters.
REQ-032 cmd_ready SHALL rise the first cycle after HRESETn deasserts; a reset mid-burst SHALL abandon the burst with no done pulse.

Verification
REQ-033 INCR4 read at 0x100, size 2, HREADY=1 -> HADDR 0x100/104/108/10C with HTRANS 10,11,11,11; 4 rvalid pulses, rlast on the 4th; done the cycle after.
REQ-034 WRAP4 write at 0x108, size 2 -> HADDR 0x108, 0x10C, 0x100, 0x104; HWDATA equals the wdata captured per wready.
REQ-035 INCR8 write, wvalid=0 for 2 cycles after beat 3 -> HTRANS=01 for 2 cycles, HADDR held at beat-4 address, then SEQ resumes; 8 wready pulses.
REQ-036 INCR4 read, slave inserts 3 wait states on beat 2 -> address phase held 3 cycles; rdata matches HRDATA on each HREADY=1.
REQ-037 INCR16 read, error on beat 5 (HRESP=1 for 2 cycles, HREADY 0 then 1) -> HTRANS=00 from the next cycle; 4 rvalid pulses; done=1, err=1.
REQ-038 cmd_size=3 at DATA_W=32, and HRESETn asserted mid-INCR8 -> size case: no HTRANS!=00, done and err pulse; reset case: all outputs at reset values immediately.

Source files
------------

// File: rtl/ahb_burst_master_if.sv
// AHB-Lite bus bundle between the burst master and a single slave.
interface ahb_burst_master_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] HADDR;
   logic [1:0]        HTRANS;
   logic              HWRITE;
   logic [2:0]        HSIZE;
   logic [2:0]        HBURST;
   logic [3:0]        HPROT;
   logic              HMASTLOCK;
   logic [DATA_W-1:0] HWDATA;
   logic [DATA_W-1:0] HRDATA;
   logic              HREADY;
   logic              HRESP;

   modport master (
      output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
      input  HRDATA, HREADY, HRESP
   );

   modport slave (
      input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
      output HRDATA, HREADY, HRESP
   );
endinterface

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: turns one command into a SINGLE/INCRn/WRAPn burst,
// streams write beats in and read beats out, and reports completion/error.
module ahb_burst_master #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [2:0]        cmd_size,
   input  logic [2:0]        cmd_burst,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wvalid,
   output logic              wready,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              rlast,
   output logic              done,
   output logic              err,
   ahb_burst_master_if.master ahb
);

   localparam int unsigned LOG2_BYTES = (DATA_W == 64) ? 3 : 2;

   typedef enum logic [2:0] {IDLE, NSEQ, SEQ, BUSY, ERR1, ERR2, DRAIN} state_t;

   state_t            state;
   logic [ADDR_W-1:0] haddr;
   logic [ADDR_W-1:0] wrap_mask;
   logic              hwrite;
   logic [2:0]        hsize;
   logic [2:0]        hburst;
   logic [3:0]        beats_left;
   logic              dp_pend;
   logic              dp_write;
   logic              dp_last;
   logic [DATA_W-1:0] hwdata_q;
   logic              wr_pend;

   logic [3:0]        cmd_beats_m1;
   logic              cmd_wrap;
   logic              cmd_bad;
   logic [ADDR_W-1:0] cmd_wrap_mask;
   logic [ADDR_W-1:0] incr_addr;
   logic [ADDR_W-1:0] next_addr;
   logic              bus_err;

   // Decode the incoming command: beat count, wrap window, legality.
   always_comb begin
      cmd_beats_m1 = 4'd0;
      cmd_wrap     = 1'b0;
      case (cmd_burst)
         3'd2:    begin cmd_beats_m1 = 4'd3;  cmd_wrap = 1'b1; end
         3'd3:          cmd_beats_m1 = 4'd3;
         3'd4:    begin cmd_beats_m1 = 4'd7;  cmd_wrap = 1'b1; end
         3'd5:          cmd_beats_m1 = 4'd7;
         3'd6:    begin cmd_beats_m1 = 4'd15; cmd_wrap = 1'b1; end
         3'd7:          cmd_beats_m1 = 4'd15;
         default:       cmd_beats_m1 = 4'd0;
      endcase
      cmd_bad = (cmd_size > 3'(LOG2_BYTES)) ||
                ((cmd_addr & ((ADDR_W'(1) << cmd_size) - ADDR_W'(1))) != '0);
      // Non-wrapping bursts use an all-ones mask so the wrap merge is a plain increment.
      cmd_wrap_mask = '1;
      if (cmd_wrap)
         cmd_wrap_mask = ((ADDR_W'(cmd_beats_m1) + ADDR_W'(1)) << cmd_size) - ADDR_W'(1);
   end

   // Next-beat address: bits inside the wrap window advance, bits above are held.
   always_comb begin
      incr_addr = haddr + (ADDR_W'(1) << hsize);
      next_addr = (haddr & ~wrap_mask) | (incr_addr & wrap_mask);
      bus_err   = dp_pend && ahb.HRESP && !ahb.HREADY;
   end

   // Burst sequencer: address phase, beat count, data-phase tracking and status.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state      <= IDLE;
         haddr      <= '0;
         wrap_mask  <= '0;
         hwrite     <= 1'b0;
         hsize      <= '0;
         hburst     <= '0;
         beats_left <= '0;
         dp_pend    <= 1'b0;
         dp_write   <= 1'b0;
         dp_last    <= 1'b0;
         hwdata_q   <= '0;
         wr_pend    <= 1'b0;
         cmd_ready  <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (dp_pend && ahb.HREADY)
            dp_pend <= 1'b0;
         case (state)
            IDLE: begin
               if (wr_pend) begin
                  if (wvalid) begin
                     wr_pend <= 1'b0;
                     state   <= NSEQ;
                  end
               end else if (cmd_ready && cmd_valid) begin
                  cmd_ready <= 1'b0;
                  if (cmd_bad) begin
                     done <= 1'b1;
                     err  <= 1'b1;
                  end else begin
                     haddr      <= cmd_addr;
                     hwrite     <= cmd_write;
                     hsize      <= cmd_size;
                     hburst     <= (cmd_burst == 3'd1) ? 3'd0 : cmd_burst;
                     wrap_mask  <= cmd_wrap_mask;
                     beats_left <= cmd_beats_m1;
                     if (!cmd_write || wvalid)
                        state <= NSEQ;
                     else
                        wr_pend <= 1'b1;
                  end
               end else begin
                  cmd_ready <= 1'b1;
               end
            end
            NSEQ, SEQ: begin
               if (bus_err) begin
                  state <= ERR1;
               end else if (ahb.HREADY) begin
                  dp_pend  <= 1'b1;
                  dp_write <= hwrite;
                  dp_last  <= (beats_left == 4'd0);
                  if (hwrite)
                     hwdata_q <= wdata;
                  if (beats_left == 4'd0) begin
                     state <= DRAIN;
                  end else begin
                     haddr      <= next_addr;
                     beats_left <= beats_left - 4'd1;
                     state      <= (!hwrite || wvalid) ? SEQ : BUSY;
                  end
               end
            end
            BUSY: begin
               if (bus_err)
                  state <= ERR1;
               else if (ahb.HREADY && wvalid)
                  state <= SEQ;
            end
            DRAIN: begin
               if (bus_err) begin
                  state <= ERR1;
               end else if (ahb.HREADY) begin
                  state     <= IDLE;
                  done      <= 1'b1;
                  cmd_ready <= 1'b1;
               end
            end
            ERR1: begin
               if (ahb.HREADY) begin
                  state <= ERR2;
                  done  <= 1'b1;
                  err   <= 1'b1;
               end
            end
            ERR2: begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // HTRANS follows the registered state directly.
   always_comb begin
      case (state)
         NSEQ:    ahb.HTRANS = 2'b10;
         SEQ:     ahb.HTRANS = 2'b11;
         BUSY:    ahb.HTRANS = 2'b01;
         default: ahb.HTRANS = 2'b00;
      endcase
   end

   assign ahb.HADDR     = haddr;
   assign ahb.HWRITE    = hwrite;
   assign ahb.HSIZE     = hsize;
   assign ahb.HBURST    = hburst;
   assign ahb.HPROT     = 4'b0011;
   assign ahb.HMASTLOCK = 1'b0;
   assign ahb.HWDATA    = (dp_pend && dp_write) ? hwdata_q : '0;

   assign wready = ((state == NSEQ) || (state == SEQ)) && hwrite && ahb.HREADY;
   assign rvalid = dp_pend && !dp_write && ahb.HREADY && !ahb.HRESP && (state != ERR1);
   assign rdata  = rvalid ? ahb.HRDATA : '0;
   assign rlast  = rvalid && dp_last;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master: reset, burst shapes, wait states,
// BUSY insertion, error response, illegal commands and mid-burst reset.
module tb_ahb_burst_master;

   logic        HCLK;
   logic        HRESETn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [2:0]  cmd_size;
   logic [2:0]  cmd_burst;
   logic [31:0] wdata;
   logic        wvalid;
   logic        wready;
   logic [31:0] rdata;
   logic        rvalid;
   logic        rlast;
   logic        done;
   logic        err;

   ahb_burst_master_if #(.DATA_W(32), .ADDR_W(32)) bus ();

   ahb_burst_master #(.DATA_W(32), .ADDR_W(32)) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_size  (cmd_size),
      .cmd_burst (cmd_burst),
      .wdata     (wdata),
      .wvalid    (wvalid),
      .wready    (wready),
      .rdata     (rdata),
      .rvalid    (rvalid),
      .rlast     (rlast),
      .done      (done),
      .err       (err),
      .ahb       (bus)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   int          total = 0;
   int          bad   = 0;

   logic [31:0] addr_log[$];
   logic [1:0]  tr_log[$];
   logic [31:0] wcap[$];
   logic [31:0] hwd_log[$];
   logic [31:0] exp_a[$];
   int          n_rv, n_rlast, rlast_cyc, done_cyc, n_done, busy_cyc, cycle_n, wcount;
   logic        last_err, any_trans, mon_wpend;
   logic [2:0]  first_burst, first_size;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr_logs();
      addr_log.delete(); tr_log.delete(); wcap.delete(); hwd_log.delete(); exp_a.delete();
      n_rv = 0; n_rlast = 0; rlast_cyc = -1; done_cyc = -1; n_done = 0; busy_cyc = 0;
      wcount = 0; last_err = 1'b0; any_trans = 1'b0; mon_wpend = 1'b0;
      first_burst = 3'd7; first_size = 3'd7;
      wdata = 32'hA5A5_0000;
   endtask

   // One clock: sample at the falling edge, then return 1 time unit after the rising edge.
   task automatic clk_cyc();
      @(negedge HCLK);
      cycle_n++;
      if (bus.HTRANS != 2'b00) any_trans = 1'b1;
      if (bus.HTRANS == 2'b01) busy_cyc++;
      if (wready) begin
         wcap.push_back(wdata);
         wcount++;
      end
      if (bus.HREADY && mon_wpend) hwd_log.push_back(bus.HWDATA);
      if (!mon_wpend) chk("hwdata_idle", bus.HWDATA, 0);
      if (bus.HREADY) mon_wpend = bus.HTRANS[1] && bus.HWRITE;
      if (bus.HREADY && bus.HTRANS[1]) begin
         if (addr_log.size() == 0) begin
            first_burst = bus.HBURST;
            first_size  = bus.HSIZE;
         end
         addr_log.push_back(bus.HADDR);
         tr_log.push_back(bus.HTRANS);
      end
      if (rvalid) begin
         n_rv++;
         chk("rdata", rdata, bus.HRDATA);
         if (rlast) begin
            n_rlast++;
            rlast_cyc = cycle_n;
         end
      end else begin
         chk("rdata_idle", rdata, 0);
      end
      if (done) begin
         n_done++;
         done_cyc = cycle_n;
         last_err = err;
      end
      @(posedge HCLK);
      #1;
      bus.HRDATA = 32'hC0DE_0000 + 32'(cycle_n);
      wdata      = 32'hA5A5_0000 + 32'(wcount);
   endtask

   task automatic send_cmd(input logic w, input logic [31:0] a, input logic [2:0] sz,
                           input logic [2:0] b);
      int n = 0;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = sz; cmd_burst = b;
      while (!cmd_ready && n < 20) begin
         clk_cyc();
         n++;
      end
      if (!cmd_ready) chk("cmd_ready_timeout", cmd_ready, 1);
      clk_cyc();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int max);
      int n = 0;
      while (n_done == 0 && n < max) begin
         clk_cyc();
         n++;
      end
      chk("done_seen", n_done, 1);
   endtask

   task automatic chk_addrs(input string tag);
      chk({tag, "_n_addr"}, addr_log.size(), exp_a.size());
      for (int i = 0; i < exp_a.size(); i++) begin
         if (i < addr_log.size()) begin
            chk({tag, "_haddr"}, addr_log[i], exp_a[i]);
            chk({tag, "_htrans"}, tr_log[i], (i == 0) ? 2'b10 : 2'b11);
         end
      end
   endtask

   task automatic chk_wr(input string tag, input int n);
      chk({tag, "_n_wready"}, wcap.size(), n);
      chk({tag, "_n_hwdata"}, hwd_log.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < wcap.size())    chk({tag, "_wcap"}, wcap[i], 32'hA5A5_0000 + 32'(i));
         if (i < hwd_log.size()) chk({tag, "_hwdata"}, hwd_log[i], 32'hA5A5_0000 + 32'(i));
      end
   endtask

   initial begin
      cycle_n = 0;
      HRESETn = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_burst = '0;
      wvalid = 1'b1;
      bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = 32'hC0DE_0000;
      clr_logs();
      repeat (2) @(posedge HCLK);
      #1;

      // Reset values
      chk("rst_htrans", bus.HTRANS, 0);
      chk("rst_haddr", bus.HADDR, 0);
      chk("rst_ctrl", {bus.HWRITE, bus.HSIZE, bus.HBURST}, 0);
      chk("rst_hwdata", bus.HWDATA, 0);
      chk("rst_status", {cmd_ready, wready, rvalid, rlast, done, err}, 0);
      chk("tied_hprot", {bus.HPROT, bus.HMASTLOCK}, 5'b0011_0);
      HRESETn = 1'b1;
      chk("cmd_ready_pre", cmd_ready, 0);
      clk_cyc();
      chk("cmd_ready_post", cmd_ready, 1);

      // INCR4 read at 0x100
      clr_logs();
      send_cmd(1'b0, 32'h100, 3'd2, 3'd3);
      chk("incr4_cmd_ready_busy", cmd_ready, 0);
      wait_done(20);
      exp_a = '{32'h100, 32'h104, 32'h108, 32'h10C};
      chk_addrs("incr4_rd");
      chk("incr4_n_rvalid", n_rv, 4);
      chk("incr4_n_rlast", n_rlast, 1);
      chk("incr4_done_lag", done_cyc - rlast_cyc, 1);
      chk("incr4_err", last_err, 0);
      chk("incr4_hburst", first_burst, 3'd3);

      // WRAP4 write at 0x108
      clr_logs();
      wvalid = 1'b1;
      send_cmd(1'b1, 32'h108, 3'd2, 3'd2);
      wait_done(20);
      exp_a = '{32'h108, 32'h10C, 32'h100, 32'h104};
      chk_addrs("wrap4_wr");
      chk_wr("wrap4_wr", 4);
      chk("wrap4_err", last_err, 0);

      // INCR8 write with wvalid dropped around beat 3
      clr_logs();
      send_cmd(1'b1, 32'h200, 3'd2, 3'd5);
      clk_cyc();
      clk_cyc();
      wvalid = 1'b0;
      clk_cyc();
      chk("busy1_htrans", bus.HTRANS, 2'b01);
      chk("busy1_haddr", bus.HADDR, 32'h20C);
      clk_cyc();
      chk("busy2_htrans", bus.HTRANS, 2'b01);
      chk("busy2_haddr", bus.HADDR, 32'h20C);
      wvalid = 1'b1;
      clk_cyc();
      chk("resume_htrans", bus.HTRANS, 2'b11);
      chk("resume_haddr", bus.HADDR, 32'h20C);
      wait_done(30);
      exp_a = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h210, 32'h214, 32'h218, 32'h21C};
      chk_addrs("incr8_wr");
      chk_wr("incr8_wr", 8);
      chk("incr8_busy_cycles", busy_cyc, 2);

      // INCR4 read with 3 wait states on beat 2
      clr_logs();
      send_cmd(1'b0, 32'h300, 3'd2, 3'd3);
      clk_cyc();
      bus.HREADY = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("wait_htrans", bus.HTRANS, 2'b11);
         chk("wait_haddr", bus.HADDR, 32'h304);
         clk_cyc();
      end
      chk("wait_haddr_end", bus.HADDR, 32'h304);
      bus.HREADY = 1'b1;
      wait_done(20);
      exp_a = '{32'h300, 32'h304, 32'h308, 32'h30C};
      chk_addrs("wait_rd");
      chk("wait_n_rvalid", n_rv, 4);

      // INCR16 read, error response on beat 5 data phase
      clr_logs();
      send_cmd(1'b0, 32'h400, 3'd2, 3'd7);
      repeat (5) clk_cyc();
      chk("err_pre_haddr", bus.HADDR, 32'h414);
      bus.HREADY = 1'b0; bus.HRESP = 1'b1;
      clk_cyc();
      chk("err1_htrans", bus.HTRANS, 2'b00);
      bus.HREADY = 1'b1; bus.HRESP = 1'b1;
      clk_cyc();
      bus.HRESP = 1'b0;
      wait_done(5);
      exp_a = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h410};
      chk_addrs("err_rd");
      chk("err_n_rvalid", n_rv, 4);
      chk("err_flag", last_err, 1);
      clk_cyc();
      chk("err_back_idle", {bus.HTRANS, cmd_ready}, 3'b00_1);

      // Illegal size and misaligned address
      clr_logs();
      send_cmd(1'b0, 32'h500, 3'd3, 3'd3);
      chk("badsize_done_err", {done, err}, 2'b11);
      clk_cyc();
      chk("badsize_pulse_end", done, 0);
      chk("badsize_cmd_ready", cmd_ready, 1);
      send_cmd(1'b1, 32'h502, 3'd2, 3'd0);
      chk("misalign_done_err", {done, err}, 2'b11);
      clk_cyc();
      chk("bad_no_transfer", any_trans, 0);
      chk("bad_no_wready", wcap.size(), 0);

      // INCR executed as SINGLE, write held in IDLE until wvalid
      clr_logs();
      wvalid = 1'b0;
      send_cmd(1'b1, 32'h700, 3'd2, 3'd1);
      clk_cyc();
      clk_cyc();
      chk("wwait_htrans", bus.HTRANS, 2'b00);
      chk("wwait_cmd_ready", cmd_ready, 0);
      wvalid = 1'b1;
      clk_cyc();
      chk("single_nseq", {bus.HTRANS, bus.HBURST, bus.HWRITE}, {2'b10, 3'd0, 1'b1});
      chk("single_haddr", bus.HADDR, 32'h700);
      wait_done(10);
      exp_a = '{32'h700};
      chk_addrs("single_wr");
      chk_wr("single_wr", 1);

      // WRAP8 halfword read at 0x1C wraps at the 16-byte boundary
      clr_logs();
      send_cmd(1'b0, 32'h1C, 3'd1, 3'd4);
      wait_done(20);
      exp_a = '{32'h1C, 32'h1E, 32'h10, 32'h12, 32'h14, 32'h16, 32'h18, 32'h1A};
      chk_addrs("wrap8_rd");
      chk("wrap8_hsize", first_size, 3'd1);
      chk("wrap8_n_rvalid", n_rv, 8);

      // Reset asserted mid-INCR8
      clr_logs();
      send_cmd(1'b0, 32'h600, 3'd2, 3'd5);
      repeat (3) clk_cyc();
      HRESETn = 1'b0;
      #1;
      chk("midrst_htrans_haddr", {bus.HTRANS, bus.HADDR}, 34'd0);
      chk("midrst_ctrl", {bus.HWRITE, bus.HSIZE, bus.HBURST}, 0);
      chk("midrst_status", {cmd_ready, wready, rvalid, rlast, done, err}, 0);
      clk_cyc();
      clk_cyc();
      HRESETn = 1'b1;
      clk_cyc();
      chk("midrst_cmd_ready", cmd_ready, 1);
      clk_cyc();
      chk("midrst_no_done", n_done, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
